uart_tx: RTL and testbench

//   UART transmitter: serialises one 8-bit byte per frame onto tx (8N1 default).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_baud_cnt.sv | 42 ++++
 rtl/uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver so that both ends
//   agree on the frame layout and FSM encoding.
//
//   Contents:
//     UART_DATA_BITS  data bits per frame (8)
//     uart_state_t    FSM encodings IDLE/START/DATA/PARITY/STOP
//     uart_parity()   parity bit for a data byte, even or odd sense
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // odd = 0 gives even parity (bit makes the total count of ones even),
   // odd = 1 gives odd parity.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d,
                                        input logic                      odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Valid/ready byte interface between a host and the UART transmitter.
//
//   Signals:
//     data   [7:0]  byte to send, meaningful while valid is high
//     valid         host offers a byte
//     ready         transmitter is idle and will take the byte on this edge
//
//   Modports:
//     master  host side (drives data/valid, observes ready)
//     slave   transmitter side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data;
   logic                      valid;
   logic                      ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Bit-period counter. Counts 0..CLK_PER_BIT-1 and flags the last cycle of
//   each bit period. Held at zero while clr is high so that the first bit of a
//   frame starts a full period from the edge that leaves clr.
//
//   Parameters:
//     CLK_PER_BIT  clk cycles per serial bit (>= 2)
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     clr      in   hold the counter at zero
//     bit_end  out  high in the last cycle of a bit period (never while clr)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
   parameter int CLK_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_end
);

   localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

   logic [CNT_W-1:0] clk_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt <= '0;
      end else if (clr || (clk_cnt == CNT_LAST)) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + CNT_W'(1);
      end
   end

   assign bit_end = !clr && (clk_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Serialises one byte per frame onto tx:
//   start bit (0), 8 data bits LSB first, optional parity bit, STOP_BITS stop
//   bits (1). Line format and bit timing match the UART receiver so the two
//   can be looped back directly.
//
//   Build option:
//     UART_TX_PARITY_EN  when defined, a parity bit follows the data bits.
//                        Its sense is set by PARITY_ODD. When undefined the
//                        frame is 8N(STOP_BITS) and no parity state exists.
//
//   Parameters:
//     CLK_PER_BIT  clk cycles per serial bit (>= 2)
//     STOP_BITS    stop bits per frame (1 or 2)
//     PARITY_ODD   0 = even parity, 1 = odd parity (parity builds only)
//
//   Ports:
//     clk    in   system clock, posedge
//     rst_n  in   asynchronous active-low reset
//     host   if   slave side of uart_tx_if (data, valid in; ready out)
//                 ready is high exactly when the FSM is in IDLE
//     tx     out  registered serial line, idles high
//     busy   out  frame in progress (FSM not in IDLE)
//     done   out  one-cycle pulse as the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 16,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_ODD  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_tx_if.slave   host,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(UART_DATA_BITS - 1);
   localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t state;
   uart_state_t state_d;

   logic [BIT_CNT_W-1:0]      bit_cnt;
   logic [BIT_CNT_W-1:0]      bit_cnt_d;
   logic                      stop_cnt;
   logic                      stop_cnt_d;
   logic [UART_DATA_BITS-1:0] shift_buf;
   logic [UART_DATA_BITS-1:0] shift_buf_d;
   logic                      tx_d;
   logic                      done_d;
   logic                      cnt_clr;
   logic                      bit_end;

`ifdef UART_TX_PARITY_EN
   logic par_bit;
   logic par_bit_d;
`else
   // PARITY_ODD has no effect without the parity bit.
   logic unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif

   // The counter idles at zero, so the bit period of the start bit begins on
   // the very edge that accepts the byte.
   uart_baud_cnt #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .bit_end(bit_end)
   );

   assign host.ready = (state == IDLE);
   assign busy       = (state != IDLE);

   // Control state: FSM, counters, registered line and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         bit_cnt  <= bit_cnt_d;
         stop_cnt <= stop_cnt_d;
         tx       <= tx_d;
         done     <= done_d;
      end
   end

   // Datapath: only read while a frame is in flight, loaded on accept.
   always_ff @(posedge clk) begin
      shift_buf <= shift_buf_d;
`ifdef UART_TX_PARITY_EN
      par_bit   <= par_bit_d;
`endif
   end

   always_comb begin
      state_d     = state;
      bit_cnt_d   = bit_cnt;
      stop_cnt_d  = stop_cnt;
      shift_buf_d = shift_buf;
      done_d      = 1'b0;
      cnt_clr     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_d   = par_bit;
`endif

      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (host.valid) begin
               state_d     = START;
               shift_buf_d = host.data;
               bit_cnt_d   = '0;
               stop_cnt_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
               // Parity is taken from the byte as accepted, not the
               // shifted buffer.
               par_bit_d   = uart_parity(host.data, 1'(PARITY_ODD));
`endif
            end
         end

         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               shift_buf_d = shift_buf >> 1;
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
`endif

         STOP: begin
            if (bit_end) begin
               if (stop_cnt == STOP_LAST) begin
                  stop_cnt_d = 1'b0;
                  state_d    = IDLE;
                  done_d     = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // tx is registered from the next state so the line changes on the
      // same edge as the state does (start bit begins on the accept edge).
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_buf_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_bit_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Three transmitters with different configurations share one clock:
//     dut0  CLK_PER_BIT=16 STOP_BITS=1 PARITY_ODD=0
//     dut1  CLK_PER_BIT=16 STOP_BITS=2 PARITY_ODD=1
//     dut2  CLK_PER_BIT=2  STOP_BITS=1 PARITY_ODD=0
//   Accepted bytes are queued as expectations; per-DUT line monitors decode
//   each frame independently and compare it with the reference frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int N0 = 16, S0 = 1, O0 = 0;
   localparam int N1 = 16, S1 = 2, O1 = 1;
   localparam int N2 = 2,  S2 = 1, O2 = 0;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n0, rst_n1, rst_n2;
   logic tx0, tx1, tx2;
   logic busy0, busy1, busy2;
   logic done0, done1, done2;

   uart_tx_if bus0 ();
   uart_tx_if bus1 ();
   uart_tx_if bus2 ();

   uart_tx #(.CLK_PER_BIT(N0), .STOP_BITS(S0), .PARITY_ODD(O0)) dut0 (
      .clk(clk), .rst_n(rst_n0), .host(bus0), .tx(tx0), .busy(busy0), .done(done0));
   uart_tx #(.CLK_PER_BIT(N1), .STOP_BITS(S1), .PARITY_ODD(O1)) dut1 (
      .clk(clk), .rst_n(rst_n1), .host(bus1), .tx(tx1), .busy(busy1), .done(done1));
   uart_tx #(.CLK_PER_BIT(N2), .STOP_BITS(S2), .PARITY_ODD(O2)) dut2 (
      .clk(clk), .rst_n(rst_n2), .host(bus2), .tx(tx2), .busy(busy2), .done(done2));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] q0[$], q1[$], q2[$];
   int st0[$], st1[$], st2[$];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- accessors ----------------
   function automatic int nper(input int id);
      return (id == 0) ? N0 : ((id == 1) ? N1 : N2);
   endfunction
   function automatic int nstop(input int id);
      return (id == 0) ? S0 : ((id == 1) ? S1 : S2);
   endfunction
   function automatic logic podd(input int id);
      return 1'((id == 0) ? O0 : ((id == 1) ? O1 : O2));
   endfunction
   function automatic logic get_tx(input int id);
      return (id == 0) ? tx0 : ((id == 1) ? tx1 : tx2);
   endfunction
   function automatic logic get_done(input int id);
      return (id == 0) ? done0 : ((id == 1) ? done1 : done2);
   endfunction
   function automatic logic get_busy(input int id);
      return (id == 0) ? busy0 : ((id == 1) ? busy1 : busy2);
   endfunction
   function automatic logic get_ready(input int id);
      return (id == 0) ? bus0.ready : ((id == 1) ? bus1.ready : bus2.ready);
   endfunction
   function automatic logic get_rst(input int id);
      return (id == 0) ? rst_n0 : ((id == 1) ? rst_n1 : rst_n2);
   endfunction

   task automatic set_in(input int id, input logic [7:0] b, input logic v);
      case (id)
         0: begin bus0.data = b; bus0.valid = v; end
         1: begin bus1.data = b; bus1.valid = v; end
         default: begin bus2.data = b; bus2.valid = v; end
      endcase
   endtask

   task automatic check(input string name, input int id, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0d expected=%0d at cycle %0d", name, id, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int frame_bits(input int id);
      return 1 + 8 + PBITS + nstop(id);
   endfunction

   // Expected line level during bit k of the frame carrying byte b.
   function automatic int exp_bit(input int id, input logic [7:0] b, input int k);
      if (k == 0) return 0;
      if (k <= 8) return int'(b[k-1]);
      if (PBITS == 1 && k == 9) return int'((^b) ^ podd(id));
      return 1;
   endfunction

   task automatic push_exp(input int id, input logic [7:0] b);
      case (id)
         0: q0.push_back(b);
         1: q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   task automatic pop_exp(input int id, output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = '0;
      case (id)
         0: if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   task automatic note_start(input int id);
      case (id)
         0: st0.push_back(cyc);
         1: st1.push_back(cyc);
         default: st2.push_back(cyc);
      endcase
   endtask

   // ---------------- line monitor ----------------
   task automatic monitor(input int id);
      int n, len, glitch, early;
      logic [7:0] expb, rxb;
      bit have, aborted, prev_done;
      n = nper(id);
      len = n * frame_bits(id);
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_done) begin
            check("done_pulse_width", id, get_done(id), 0);
            prev_done = 1'b0;
         end
         if (get_rst(id) && get_tx(id) == 1'b0) begin
            note_start(id);
            pop_exp(id, expb, have);
            check("frame_expected", id, have, 1);
            glitch = 0; early = 0; aborted = 1'b0; rxb = '0;
            for (int c = 0; c < len; c++) begin
               if (c > 0) @(negedge clk);
               if (!get_rst(id)) begin
                  aborted = 1'b1;
                  break;
               end
               if (int'(get_tx(id)) != exp_bit(id, expb, c / n)) glitch++;
               if (get_done(id)) early++;
               if ((c % n) == n / 2 && c / n >= 1 && c / n <= 8) rxb[c/n-1] = get_tx(id);
            end
            if (!aborted) begin
               @(negedge clk);
               check("rx_byte", id, rxb, expb);
               check("bit_timing_errors", id, glitch, 0);
               check("done_before_end", id, early, 0);
               if (get_rst(id)) begin
                  check("done_at_frame_end", id, get_done(id), 1);
                  check("line_high_after_frame", id, get_tx(id), 1);
                  prev_done = 1'b1;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) check("ready_eq_not_busy", i, get_ready(i), !get_busy(i));
   end

   // ---------------- stimulus ----------------
   task automatic send(input int id, input logic [7:0] b, input bit hold);
      int waited;
      waited = 0;
      @(negedge clk);
      set_in(id, b, 1'b1);
      while (!get_ready(id) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check("accepted", id, get_ready(id), 1);
      if (get_ready(id)) begin
         push_exp(id, b);
         @(posedge clk);
         #1;
      end
      // Scribble on data after accept; the frame in flight must not change.
      if (!hold) set_in(id, 8'($urandom), 1'b0);
   endtask

   task automatic wait_done(input int id, output int k);
      k = 0;
      @(negedge clk);
      while (!get_done(id) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", id, get_done(id), 1);
   endtask

   task automatic rand_stream(input int id, input int count);
      bit hold;
      for (int i = 0; i < count; i++) begin
         hold = (i < count - 1) && ($urandom_range(0, 1) == 1);
         send(id, 8'($urandom), hold);
         if (!hold) repeat ($urandom_range(0, 25)) @(negedge clk);
      end
   endtask

   initial begin
      int k, dn;
      set_in(0, 8'h00, 1'b0);
      set_in(1, 8'h00, 1'b0);
      set_in(2, 8'h00, 1'b0);
      rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none
      #2;
      rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset_tx", i, get_tx(i), 1);
         check("reset_ready", i, get_ready(i), 1);
         check("reset_busy", i, get_busy(i), 0);
         check("reset_done", i, get_done(i), 0);
      end
      repeat (3) @(negedge clk);
      rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;

      // 0x55: alternating line, done a full frame after accept
      send(0, 8'h55, 1'b0);
      wait_done(0, k);
      check("done_latency", 0, k, frame_bits(0) * N0);

      // back-to-back with valid held
      send(0, 8'hA5, 1'b1);
      send(0, 8'h3C, 1'b0);
      wait_done(0, k);
      check("back_to_back_gap", 0, st0[st0.size()-1] - st0[st0.size()-2], frame_bits(0) * N0 + 1);

      // valid pulsed mid-frame is ignored
      send(0, 8'h00, 1'b0);
      repeat (40) @(negedge clk);
      set_in(0, 8'hFF, 1'b1);
      check("ready_while_busy", 0, bus0.ready, 0);
      @(negedge clk);
      set_in(0, 8'hFF, 1'b0);
      wait_done(0, k);
      repeat (20) @(negedge clk);

      // reset in the 4th data bit abandons the frame
      send(0, 8'h81, 1'b0);
      repeat (70) @(posedge clk);
      #3 rst_n0 = 1'b0;
      #1;
      check("midframe_reset_tx", 0, tx0, 1);
      check("midframe_reset_busy", 0, busy0, 0);
      check("midframe_reset_ready", 0, bus0.ready, 1);
      repeat (2) @(negedge clk);
      rst_n0 = 1'b1;
      dn = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0) dn++;
      end
      check("no_done_after_reset", 0, dn, 0);
      send(0, 8'h42, 1'b0);
      wait_done(0, k);

      // 0x07 on even and odd parity sense
      send(0, 8'h07, 1'b0);
      wait_done(0, k);
      send(1, 8'h07, 1'b0);
      wait_done(1, k);

      // two stop bits
      send(1, 8'hC3, 1'b0);
      wait_done(1, k);
      check("done_latency", 1, k, frame_bits(1) * N1);

      // randomised traffic on all three in parallel
      fork
         rand_stream(0, 12);
         rand_stream(1, 6);
         rand_stream(2, 40);
      join

      k = 0;
      while ((q0.size() + q1.size() + q2.size() != 0 || !bus0.ready || !bus1.ready || !bus2.ready)
             && k < 5000) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      check("pending_expect", 0, q0.size(), 0);
      check("pending_expect", 1, q1.size(), 0);
      check("pending_expect", 2, q2.size(), 0);
      check("final_ready", 0, bus0.ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
